// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output channel among N_REQ
// requesters; each ownership lasts up to MAX_BURST beats, followed by one IDLE cycle.
module rr_reg_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] din,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       dout,
  output logic                dout_valid,
  input  logic                out_ready
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    win, owner_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic [N_REQ-1:0] gnt_d;
  logic             slot_free, own_req, beat, last_beat;
  logic [DW-1:0]    din_sel;

  // First set request scanning from p upward, wrapping modulo N_REQ.
  function automatic logic [PW-1:0] pick_winner(input logic [N_REQ-1:0] r,
                                                 input logic [PW-1:0]    p);
    logic [PW-1:0] w;
    logic [PW-1:0] cand;
    logic          found;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PW'((int'(p) + k) % N_REQ);
      if (!found && r[cand]) begin
        w     = cand;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    din_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == PW'(i)) din_sel = din[i*DW +: DW];
    end
  end

  assign win       = pick_winner(req, ptr_q);
  assign owner_nxt = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign slot_free = !dout_valid || out_ready;
  assign own_req   = req[owner_q];
  assign beat      = (state_q == OWN) && own_req && slot_free;
  assign last_beat = beat && (count_q == CW'(MAX_BURST - 1));
  // gnt is one-hot on the owner while in OWN, so it doubles as the ack mask.
  assign ack       = beat ? gnt : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    count_d = count_q;
    gnt_d   = gnt;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          owner_d = win;
          count_d = '0;
          gnt_d   = N_REQ'(1) << win;
        end
      end
      OWN: begin
        if (!own_req || last_beat) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = owner_nxt;
        end else if (beat) begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      count_q <= '0;
      gnt     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      count_q <= count_d;
      gnt     <= gnt_d;
    end
  end

  // Output register: a new beat wins over a consume in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (beat) begin
      dout       <= din_sel;
      dout_valid <= 1'b1;
    end else if (out_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule
